// File: rtl/pdm_mic_decim.sv
// PDM microphone receiver: mic_clk divider, 2-flop data sync, integrate-and-dump decimator, one-deep output register.
// Optional build macro PDM_SIGNED_OUT_EN selects a signed, mid-scale-removed PCM word instead of the raw ones-count.
module pdm_mic_decim #(
  parameter int DIV_HALF = 1300,
  parameter int DECIM    = 64,
  parameter int SKIP     = 2,
  parameter int PCM_W    = $clog2(DECIM + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic             mic_clk,
  input  logic             mic_data,
  output logic [PCM_W-1:0] pcm_data,
  output logic             pcm_valid,
  input  logic             pcm_ready,
  output logic             overrun,
  input  logic             clear_ovr
);

  localparam int DIV_W  = $clog2(DIV_HALF);
  localparam int BC_W   = $clog2(DECIM);
  localparam int SKIP_W = (SKIP > 0) ? $clog2(SKIP + 1) : 1;

  localparam logic [DIV_W-1:0]  DIV_RELOAD = DIV_W'(DIV_HALF - 1);
  localparam logic [BC_W-1:0]   BC_LAST    = BC_W'(DECIM - 1);
  localparam logic [SKIP_W-1:0] SKIP_INIT  = SKIP_W'(SKIP);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              mic_clk_q, mic_clk_d;
  logic              sync1_q, sync2_q;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [PCM_W-1:0]  acc_q, acc_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic [PCM_W-1:0]  pcm_data_q, pcm_data_d;
  logic              pcm_valid_q, pcm_valid_d;
  logic              overrun_q, overrun_d;

  logic              strobe;
  logic              word_done;
  logic              deliver;
  logic [PCM_W-1:0]  word;
  logic [PCM_W-1:0]  word_out;

  // Control and datapath: IDLE (or losing en) reloads everything, so a partial word never survives a restart.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    mic_clk_d = mic_clk_q;
    bit_cnt_d = bit_cnt_q;
    acc_d     = acc_q;
    skip_d    = skip_q;
    strobe    = 1'b0;
    word_done = 1'b0;
    deliver   = 1'b0;
    word      = acc_q + {{(PCM_W-1){1'b0}}, sync2_q};

    if (state_q == IDLE || !en) begin
      div_d     = DIV_RELOAD;
      mic_clk_d = 1'b0;
      bit_cnt_d = '0;
      acc_d     = '0;
      skip_d    = SKIP_INIT;
      if (state_q == IDLE) begin
        if (en) state_d = (SKIP > 0) ? SETTLE : RUN;
      end else begin
        state_d = IDLE;
      end
    end else begin
      if (div_q == '0) begin
        mic_clk_d = ~mic_clk_q;
        div_d     = DIV_RELOAD;
        strobe    = mic_clk_q;
      end else begin
        div_d = div_q - DIV_W'(1);
      end

      if (strobe) begin
        if (bit_cnt_q == BC_LAST) begin
          word_done = 1'b1;
          acc_d     = '0;
          bit_cnt_d = '0;
        end else begin
          acc_d     = word;
          bit_cnt_d = bit_cnt_q + BC_W'(1);
        end
      end

      // Settling words are counted down and thrown away, including the one that finishes the count.
      if (word_done) begin
        if (state_q == SETTLE) begin
          skip_d = skip_q - SKIP_W'(1);
          if (skip_q == SKIP_W'(1)) state_d = RUN;
        end else begin
          deliver = 1'b1;
        end
      end
    end
  end

`ifdef PDM_SIGNED_OUT_EN
  assign word_out = word - PCM_W'(DECIM / 2);
`else
  assign word_out = word;
`endif

  // Single output register: newest word always wins; losing an unread word flags overrun.
  always_comb begin
    pcm_data_d  = pcm_data_q;
    pcm_valid_d = pcm_valid_q;
    overrun_d   = overrun_q;

    if (deliver) begin
      pcm_data_d  = word_out;
      pcm_valid_d = 1'b1;
    end else if (pcm_valid_q && pcm_ready) begin
      pcm_valid_d = 1'b0;
    end

    if (deliver && pcm_valid_q && !pcm_ready) begin
      overrun_d = 1'b1;
    end else if (clear_ovr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      div_q       <= DIV_RELOAD;
      mic_clk_q   <= 1'b0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      bit_cnt_q   <= '0;
      acc_q       <= '0;
      skip_q      <= SKIP_INIT;
      pcm_data_q  <= '0;
      pcm_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      mic_clk_q   <= mic_clk_d;
      sync1_q     <= mic_data;
      sync2_q     <= sync1_q;
      bit_cnt_q   <= bit_cnt_d;
      acc_q       <= acc_d;
      skip_q      <= skip_d;
      pcm_data_q  <= pcm_data_d;
      pcm_valid_q <= pcm_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign mic_clk   = mic_clk_q;
  assign pcm_data  = pcm_data_q;
  assign pcm_valid = pcm_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/pdm_mic_decim.md
Name: pdm_mic_decim

Overview:
- Receive end of the PDM microphone link.
- Generates the microphone bit clock from the system clock and samples the 1-bit PDM stream.
- Integrate-and-dump decimates the stream into PCM words.
- Delivers PCM words over a valid/ready handshake to the audio buffer/FIFO downstream.

Parameters:
- DIV_HALF, 1300: system clocks per half-period of mic_clk. mic_clk = f_clk/(2*DIV_HALF). Legal range ≥2.
- DECIM, 64: PDM bits per PCM word. Must be a power of two, ≥4.
- SKIP, 2: PCM words discarded after each enable (mic start-up settling). 0 = none.
- PCM_W, $clog2(DECIM+1): PCM word width (7 for DECIM=64).

Ports:
- clk  in  1  system clock; all logic on its posedge.
- reset  in  1  synchronous, active-low; reset==0 at posedge clk resets the block.
- en  in  1  capture enable.
- mic_clk  out  1  PDM bit clock to the microphone.
- mic_data  in  1  PDM data from the microphone (asynchronous).
- pcm_data  out  PCM_W  decimated sample.
- pcm_valid  out  1  pcm_data holds an unconsumed word.
- pcm_ready  in  1  consumer accepts the word this cycle.
- overrun  out  1  sticky: a word was overwritten before it was consumed.
- clear_ovr  in  1  clears overrun.

Behaviour:
- Reset values:
  - mic_clk=0, pcm_data=0, pcm_valid=0, overrun=0.
  - Divider counter = DIV_HALF-1; bit_cnt=0; acc=0; skip_cnt=SKIP; sync flops=0.
  - State IDLE.
- States:
  - IDLE: mic_clk held 0. Counters reloaded, acc cleared. en=1 -> SETTLE if SKIP>0, else RUN.
  - SETTLE: capture runs normally, but completed words are dropped. skip_cnt decrements per completed word. Leaves for RUN on the word that takes skip_cnt from 1 to 0; that word is also dropped.
  - RUN: completed words go to the output stage.
  - From SETTLE or RUN, en=0 -> IDLE next cycle. A partial word in acc is discarded. An already-valid output word is kept until consumed.
- Divider:
  - Counts down while not IDLE.
  - At 0: toggle mic_clk, reload DIV_HALF-1.
  - First mic_clk rise occurs DIV_HALF cycles after entering SETTLE/RUN.
- Sampling:
  - mic_data passes through a 2-flop synchroniser.
  - Sample strobe is the cycle in which mic_clk toggles 1->0; the synchronised bit is taken in that cycle.
- Accumulation:
  - Each strobe: acc += bit, bit_cnt += 1.
  - On the strobe with bit_cnt==DECIM-1: word = acc+bit (0..DECIM, fits PCM_W); acc and bit_cnt reset to 0 in the same cycle. No wrap is possible.
- Output stage, one register:
  - Word completes in RUN: pcm_data <= word, pcm_valid <= 1 on the next clk edge (latency 1 cycle after the strobe).
  - pcm_valid=1 and pcm_ready=1 with no new word: pcm_valid <= 0; pcm_data holds its value.
  - New word with pcm_valid=1 and pcm_ready=1 in the same cycle: load the new word, pcm_valid stays 1, no overrun.
  - New word with pcm_valid=1 and pcm_ready=0: newest word wins; overrun <= 1.
  - pcm_ready while pcm_valid=0 is ignored.
- overrun:
  - clear_ovr=1 clears it.
  - Simultaneous set and clear: set wins.
- Reset mid-operation: all state returns to reset values within one edge. A pending word is lost.

Optional Feature:
- Macro PDM_SIGNED_OUT_EN.
- Defined: pcm_data = word - DECIM/2 in two's complement, range -DECIM/2..+DECIM/2, same PCM_W width. An idle 50% density stream yields 0. Reset value 0 is unchanged.
- Undefined: pcm_data is the unsigned ones-count, 0..DECIM.

Test Plan:
- Reset, en=1, DIV_HALF=2 -> mic_clk period 4 clk, first rise 2 cycles after entering SETTLE; reset=0 mid-run -> all outputs 0 next edge.
- DECIM=8, SKIP=0, mic_data constant 1, pcm_ready=1 -> pcm_data=8 every 8 mic_clk periods, pulses one cycle long; constant 0 -> 0.
- SKIP=2, alternating 1/0 stream, DECIM=8 -> first two words dropped, third word =4 (signed build: 0).
- pcm_ready=0 across two completed words -> pcm_valid=1, pcm_data = second word, overrun=1; clear_ovr in the same cycle as a third overwrite -> overrun stays 1.
- Word completes in the same cycle pcm_ready=1 with pcm_valid=1 -> new word loaded, pcm_valid stays 1, overrun=0.
- en dropped after 5 of 8 bits, then re-enabled -> partial word discarded, pending valid word kept until pcm_ready, next word counts from a fresh acc=0.
